if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word-addressed requests to instruction memory over a req/ack handshake, which allows multi-cycle memory latency.
- Buffers returned instructions, with their PCs, in a small FIFO.
- Presents the FIFO head to IF/ID, honouring the hazard unit's write-enable (stall) and the branch redirect/flush from MEM.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- RESET_PC, 64'd0, fetch PC loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  taken branch resolved; flush and refetch from redirect_pc.
- redirect_pc  input  64  branch target (word address).
- imem_req  output  1  fetch request valid.
- imem_addr  output  64  fetch word address.
- imem_ack  input  1  memory returns imem_rdata for the current request this cycle.
- imem_rdata  input  32  fetched instruction.
- deq_ready  input  1  IF/ID write enable; head consumed when out_valid && deq_ready.
- out_valid  output  1  head entry valid.
- out_pc  output  64  PC of head entry.
- out_instruction  output  32  head instruction; 32'b0 (bubble) when !out_valid.
- occupancy  output  log2(DEPTH)+1  entries held.

Behaviour:
- Reset is synchronous and active-high; one clock domain.
- Reset values: fetch_pc=RESET_PC, state=IDLE, FIFO empty, occupancy=0, out_valid=0, out_pc=0, out_instruction=0.
- State machine:
  - IDLE: imem_req=1 when occupancy<DEPTH and no redirect this cycle, with imem_addr=fetch_pc.
    - imem_ack in the same cycle: enqueue {fetch_pc, imem_rdata}, fetch_pc+=1, stay IDLE.
    - No ack: go REQ.
  - REQ: imem_req=1, imem_addr held stable until ack.
    - On ack: enqueue, fetch_pc+=1, go IDLE.
  - DISCARD: entered when a redirect arrives in REQ without ack.
    - imem_req held high with the old address; the handshake is never abandoned.
    - On ack: drop the data, go IDLE.
- Handshake: imem_req must not drop, and imem_addr must not change, between assertion and ack. imem_ack while imem_req=0 is ignored.
- Redirect (redirect_valid=1), with priority over everything else:
  - FIFO cleared (occupancy=0 next cycle).
  - fetch_pc <= redirect_pc.
  - No dequeue this cycle.
  - Ack data arriving in the same cycle is dropped.
  - In IDLE, no new request is issued that cycle.
  - REQ without ack goes to DISCARD; REQ with ack goes to IDLE.
  - Redirect in DISCARD updates fetch_pc again; the state stays DISCARD unless ack arrives.
- Output:
  - Head is read combinationally from the FIFO; first data is visible the cycle after the enqueuing edge.
  - Head and out_valid are held unchanged while deq_ready=0.
- Simultaneous enqueue and dequeue: allowed; occupancy unchanged.
- Full (occupancy==DEPTH): no request issued, even if a dequeue occurs that cycle (registered credit check).
- fetch_pc wraps modulo 2^64.
- Pointers are log2(DEPTH) bits wide and wrap naturally; occupancy tracks separately.
- Reset mid-request: state returns to IDLE and any later ack is ignored. The memory model must tolerate request withdrawal on reset.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined:
  - If the FIFO is empty, imem_ack=1, and there is no redirect, the returning instruction drives out_valid/out_pc/out_instruction combinationally in the same cycle.
  - If deq_ready=1, it is consumed without being enqueued; otherwise it is enqueued normally.
  - Zero-latency fetch with a combinational memory.
- When not defined: returned data always passes through the FIFO; one cycle of fetch-to-output latency.

Test Plan:
- Streaming: imem_ack tied 1, deq_ready=1, reset released at cycle 0 -> out_pc = 0,1,2,3… on consecutive cycles starting at cycle 1 (cycle 0 with IFQ_BYPASS_EN), out_valid continuously 1.
- Stall/full: deq_ready=0 for 8 cycles, ack tied 1 -> occupancy rises to 4 and holds, imem_req=0 once full, head out_pc=0 unchanged. Release deq_ready -> PCs 0,1,2,3,4 in order, no loss or duplicates.
- Slow memory: ack 3 cycles after req -> imem_req and imem_addr stable across all 3 cycles, one enqueue per ack, out_pc sequence 0,1,2.
- Redirect mid-request: redirect_valid with redirect_pc=0x40 while REQ at addr 5 is waiting -> FIFO empty, state DISCARD, ack for addr 5 dropped, next imem_addr=0x40, next out_pc=0x40.
- Redirect with ack and deq in the same cycle: occupancy=2 -> next cycle occupancy=0, out_valid=0, out_instruction=0, ack data absent from the output stream.
- Reset mid-operation: reset asserted with occupancy=3 in REQ -> next cycle occupancy=0, imem_req reflects IDLE, imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: owns the fetch PC, issues req/ack fetches and buffers results.
// Optional same-cycle bypass of returning data to the output when IFQ_BYPASS_EN is defined.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     imem_req,
    output logic [63:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     deq_ready,
    output logic                     out_valid,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instruction,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [63:0]     req_addr_q, req_addr_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [63:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic full, empty, ack_fire, data_keep, bypass, enq, deq;

    // Handshake and datapath decode
    always_comb begin
        full      = (count_q == FullCount);
        empty     = (count_q == '0);
        imem_req  = 1'b0;
        imem_addr = fetch_pc_q;
        case (state_q)
            StIdle:  imem_req = !full && !redirect_valid;
            StReq, StDiscard: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
            end
            default: imem_req = 1'b0;
        endcase

        ack_fire  = imem_req && imem_ack;
        data_keep = ack_fire && !redirect_valid && (state_q != StDiscard);
`ifdef IFQ_BYPASS_EN
        bypass    = empty && data_keep;
`else
        bypass    = 1'b0;
`endif
        out_valid       = !empty || bypass;
        out_pc          = 64'd0;
        out_instruction = 32'd0;
        if (!empty) begin
            out_pc          = pc_mem[rd_ptr_q];
            out_instruction = instr_mem[rd_ptr_q];
        end else if (bypass) begin
            out_pc          = imem_addr;
            out_instruction = imem_rdata;
        end

        deq       = !empty && deq_ready && !redirect_valid;
        // A bypassed word that is consumed immediately never occupies a slot
        enq       = data_keep && !(bypass && deq_ready);
        occupancy = count_q;
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            StIdle: begin
                if (imem_req && !imem_ack) begin
                    state_d    = StReq;
                    req_addr_d = fetch_pc_q;
                end
            end
            StReq: begin
                if (imem_ack) begin
                    state_d = StIdle;
                end else if (redirect_valid) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (data_keep) begin
            fetch_pc_d = imem_addr + 64'd1;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
        count_d = redirect_valid ? '0
                                 : count_q + (PtrW + 1)'(enq) - (PtrW + 1)'(deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]    <= imem_addr;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: queue-based reference model plus directed scenarios.
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'd0;
`ifdef IFQ_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   redirect_valid;
    logic [63:0]            redirect_pc;
    logic                   imem_req;
    logic [63:0]            imem_addr;
    logic                   imem_ack;
    logic [31:0]            imem_rdata;
    logic                   deq_ready;
    logic                   out_valid;
    logic [63:0]            out_pc;
    logic [31:0]            out_instruction;
    logic [$clog2(DEPTH):0] occupancy;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .deq_ready       (deq_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding-request flag, drop flag, and a queue of fetched words
    ent_t        m_q[$];
    logic [63:0] m_fetch_pc  = 64'd0;
    logic [63:0] m_busy_addr = 64'd0;
    bit          m_busy      = 1'b0;
    bit          m_drop      = 1'b0;
    bit          model_ok    = 1'b0;

    initial begin : compare
        int          sz;
        bit          e_req, fire, byp, e_valid;
        logic [63:0] e_addr;
        ent_t        head;
        forever begin
            @(negedge clk);
            sz      = m_q.size();
            e_req   = m_busy ? 1'b1 : (sz < int'(DEPTH) && !redirect_valid);
            e_addr  = m_busy ? m_busy_addr : m_fetch_pc;
            fire    = e_req && imem_ack;
            byp     = Byp && sz == 0 && fire && !redirect_valid && !m_drop;
            e_valid = (sz > 0) || byp;
            head    = (sz > 0) ? m_q[0] : (byp ? {e_addr, imem_rdata} : '0);
            if (model_ok) begin
                check("m_imem_req", 64'(imem_req), 64'(e_req));
                if (e_req) check("m_imem_addr", imem_addr, e_addr);
                check("m_out_valid", 64'(out_valid), 64'(e_valid));
                check("m_out_pc", out_pc, head.pc);
                check("m_out_instr", 64'(out_instruction), 64'(head.instr));
                check("m_occupancy", 64'(occupancy), 64'(sz));
            end
            if (reset) begin
                m_q.delete();
                m_fetch_pc = RESET_PC;
                m_busy     = 1'b0;
                m_drop     = 1'b0;
                model_ok   = 1'b1;
            end else if (model_ok) begin
                if (redirect_valid) begin
                    m_q.delete();
                    if (fire) begin
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else if (m_busy) begin
                        m_drop = 1'b1;
                    end
                    m_fetch_pc = redirect_pc;
                end else begin
                    if (e_valid && deq_ready && sz > 0) void'(m_q.pop_front());
                    if (fire) begin
                        if (!m_drop) begin
                            m_fetch_pc = e_addr + 64'd1;
                            if (!(byp && deq_ready)) m_q.push_back({e_addr, imem_rdata});
                        end
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else if (e_req) begin
                        m_busy      = 1'b1;
                        m_busy_addr = e_addr;
                    end
                end
            end
        end
    end

    task automatic drive(input bit rst, input bit rv, input logic [63:0] rpc, input bit ack,
                         input bit dq);
        @(posedge clk);
        #1;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = $urandom();
        deq_ready      = dq;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin : stimulus
        int          lat;
        logic [63:0] got[$];
        logic [63:0] first_pc;
        bit          found;
        int          thr;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        deq_ready      = 1'b0;
        lat            = Byp ? 0 : 1;

        // Streaming with an always-ready memory
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 1, 1);
            sample();
            if (k >= lat) begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_pc", out_pc, 64'(k - lat));
            end
        end

        // Fill to full under stall, then drain in order
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1, 0);
            sample();
            check("fill_occ", 64'(occupancy), 64'((k < 4) ? k : 4));
        end
        check("full_req", 64'(imem_req), 64'd0);
        check("full_head", out_pc, 64'd0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 1);
            sample();
            check("drain_pc", out_pc, 64'(k));
        end

        // Slow memory: ack on the third cycle of each request
        drive(1, 0, 0, 0, 0);
        got.delete();
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 3; w++) begin
                drive(0, 0, 0, w == 2, 1);
                sample();
                check("slow_req", 64'(imem_req), 64'd1);
                check("slow_addr", imem_addr, 64'(n));
                if (out_valid) got.push_back(out_pc);
            end
        end
        drive(0, 0, 0, 0, 1);
        sample();
        if (out_valid) got.push_back(out_pc);
        check("slow_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < got.size(); i++) check("slow_pc", got[i], 64'(i));

        // Redirect while a request to addr 5 is outstanding
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        sample();
        check("redir_pre_addr", imem_addr, 64'd5);
        drive(0, 1, 64'h40, 0, 1);
        sample();
        check("redir_hold_addr", imem_addr, 64'd5);
        drive(0, 0, 0, 1, 1);
        sample();
        check("discard_occ", 64'(occupancy), 64'd0);
        check("discard_req", 64'(imem_req), 64'd1);
        check("discard_addr", imem_addr, 64'd5);
        check("discard_valid", 64'(out_valid), 64'd0);
        drive(0, 0, 0, 1, 1);
        sample();
        check("refetch_addr", imem_addr, 64'h40);
        found    = out_valid;
        first_pc = out_pc;
        drive(0, 0, 0, 0, 1);
        sample();
        if (!found && out_valid) begin
            found    = 1'b1;
            first_pc = out_pc;
        end
        check("refetch_seen", 64'(found), 64'd1);
        check("refetch_pc", first_pc, 64'h40);

        // Redirect coinciding with ack and dequeue at occupancy 2
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 64'h100, 1, 1);
        sample();
        check("flush_pre_occ", 64'(occupancy), 64'd2);
        drive(0, 0, 0, 0, 0);
        sample();
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_instr", 64'(out_instruction), 64'd0);

        // Reset while a request is pending with three entries held
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        sample();
        check("rst_pre_occ", 64'(occupancy), 64'd3);
        check("rst_pre_addr", imem_addr, 64'd3);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        sample();
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_req", 64'(imem_req), 64'd1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 64'(out_valid), 64'd0);

        // Randomized traffic; dequeue rate varies per block to reach full and empty
        thr = 3;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) thr = $urandom_range(0, 3);
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFD
                                              : {$urandom(), $urandom()},
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) <= thr);
        end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
